ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Converts the byte stream from the PS/2 byte receiver into the keyboard state consumed by the game counter: a per-key pressed bitmap, the 9-bit code of the most recent key event, and a one-cycle event strobe. It sits between the PS/2 byte receiver (bit-level framing and parity) and the game counter. It decodes scan-code-set-2 prefixes (E0 extended, F0 break, E1 pause) with a small state machine. It also recovers from truncated sequences by timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 2_000_000: idle cycles inside a partial sequence before abort (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- rx_err  in  1  one-cycle strobe on parity or framing error; byte discarded.
- key_down  out  512  pressed bitmap indexed by {ext,code}; the game counter connects [127:0].
- last_change  out  9  {ext, code} of the last completed make or break.
- key_valid  out  1  one-cycle strobe, coincident with the key_down/last_change update.
- seq_abort  out  1  one-cycle strobe when a partial sequence is dropped (debug LED).

## Operation
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, skipping).
- IDLE handling, per byte:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, with skip counter = 7.
  - 00, AA, EE, FA, FE, FF are ignored; stay in IDLE.
  - Any other byte c is a make {0,c}.
- EXT handling, per byte:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shift) -> IDLE, no event.
  - E0 stays in EXT.
  - Other byte c is a make {1,c}.
- BRK handling: byte c is a break {0,c}.
- EXT_BRK handling, per byte:
  - 12 or 59 -> IDLE, no event.
  - Other byte c is a break {1,c}.
- PAUSE: decrement the skip counter per byte; at 0 -> IDLE. No event and no key_down change; Pause is not tracked.
- Make: key_down[idx]<=1, last_change<=idx, key_valid pulse, -> IDLE.
- Break: key_down[idx]<=0, last_change<=idx, key_valid pulse, -> IDLE.
- Typematic repeats (make of an already-set bit) still pulse key_valid. The consumer filters them with its own previous-cycle key_down[last_change] check.
- A break for an unset bit still pulses key_valid; the bit stays 0.
- A prefix byte received in BRK or EXT_BRK (E0/F0/E1) is treated as a protocol error: seq_abort pulse, -> IDLE, byte dropped.
- rx_err in any non-IDLE state: seq_abort, -> IDLE. In IDLE it is ignored.
- Timeout: a 21-bit idle counter runs in every state except IDLE and resets on each rx_valid. When it reaches TIMEOUT_CYCLES-1: seq_abort, -> IDLE.
- key_down is never cleared except by rst. last_change holds its value between events.

## Timing
- Reset values: key_down=0, last_change=0, key_valid=0, seq_abort=0, state=IDLE, counters=0.
- Latency: the byte completing a sequence, on rx_valid in cycle N, gives key_down, last_change and key_valid updated at cycle N+1 (registered outputs).
- key_valid and seq_abort are high for exactly one cycle. They are never high together.
- rx_valid and rx_err in the same cycle: rx_err wins and the byte is discarded.
- rx_valid in the same cycle as timeout expiry: the byte is processed from IDLE and no abort is raised.
- Back-to-back rx_valid every cycle is supported with no stall; there is no ready signal.
- rst asserted mid-sequence: the next cycle is IDLE with all outputs at reset values, and the partial sequence is lost.

## Structure
- Package ps2_pkg holds:
  - state enum;
  - byte constants: PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1, FAKE_SHIFT_L=8'h12, FAKE_SHIFT_R=8'h59, PAUSE_SKIP=7;
  - the ignored-byte list;
  - KEY_SPACE=9'h029 and KEY_BACK=9'h066, shared with the game counter.
- Single module, no sub-module. The timeout counter is inline; the byte receiver stays a separate upstream block.

## Test plan
- 1C -> key_down[0x01C]=1, last_change=0x01C, key_valid one pulse at N+1. Then F0 1C -> bit cleared, last_change=0x01C, second pulse.
- E0 75 then E0 F0 75 -> key_down[0x175] set then cleared. key_down[0x075] stays 0 throughout.
- 29 29 29 (repeat) -> three key_valid pulses, key_down[0x029]=1 throughout. F0 29 -> cleared.
- E1 14 77 E1 F0 14 F0 77 -> no key_valid, key_down unchanged, state IDLE afterwards. Then 66 -> make 0x066.
- F0 followed by TIMEOUT_CYCLES idle cycles -> single seq_abort pulse. Then 1C -> make (not break) of 0x01C.
- E0 with rx_err -> seq_abort, no event. Reset asserted after F0 -> all outputs 0. Then 2D -> make 0x02D.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code-set-2 constants and state encoding for the PS/2 key tracker
// and the game counter that consumes its key bitmap.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_t;

    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_BRK      = 8'hF0;
    localparam logic [7:0] PFX_PAUSE    = 8'hE1;
    localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_R = 8'h59;
    localparam logic [2:0] PAUSE_SKIP   = 3'd7;

    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_BACK  = 9'h066;

    // Keyboard replies and error codes that never start a key sequence
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE,
            8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_EXT) || (b == PFX_BRK) || (b == PFX_PAUSE);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
    endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// Scan-code-set-2 decoder: turns PS/2 bytes into a pressed-key bitmap,
// last-event code and event/abort strobes, with timeout recovery.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_err,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid,
    output logic         seq_abort
);

    localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next, cur;
    logic [2:0]  skip, skip_next;
    logic [20:0] tmo_cnt, tmo_next;
    logic        expired;
    logic        ev, ev_brk, abort;
    logic [8:0]  ev_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            skip    <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            skip    <= skip_next;
            tmo_cnt <= tmo_next;
        end
    end

    always_comb begin
        state_next = state;
        skip_next  = skip;
        ev         = 1'b0;
        ev_brk     = 1'b0;
        ev_idx     = 9'd0;
        abort      = 1'b0;
        expired    = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
        // A byte arriving on the expiry cycle starts afresh from IDLE
        cur        = expired ? ST_IDLE : state;

        if (rx_err) begin
            if (state != ST_IDLE) begin
                abort      = 1'b1;
                state_next = ST_IDLE;
            end
        end else if (rx_valid) begin
            state_next = ST_IDLE;
            unique case (cur)
                ST_IDLE: begin
                    if (rx_data == PFX_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == PFX_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data == PFX_PAUSE) begin
                        state_next = ST_PAUSE;
                        skip_next  = PAUSE_SKIP;
                    end else if (!is_ignored(rx_data)) begin
                        ev     = 1'b1;
                        ev_idx = {1'b0, rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data == PFX_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (rx_data == PFX_EXT) begin
                        state_next = ST_EXT;
                    end else if (!is_fake_shift(rx_data)) begin
                        ev     = 1'b1;
                        ev_idx = {1'b1, rx_data};
                    end
                end
                ST_BRK: begin
                    if (is_prefix(rx_data)) begin
                        abort = 1'b1;
                    end else begin
                        ev     = 1'b1;
                        ev_brk = 1'b1;
                        ev_idx = {1'b0, rx_data};
                    end
                end
                ST_EXT_BRK: begin
                    if (is_prefix(rx_data)) begin
                        abort = 1'b1;
                    end else if (!is_fake_shift(rx_data)) begin
                        ev     = 1'b1;
                        ev_brk = 1'b1;
                        ev_idx = {1'b1, rx_data};
                    end
                end
                ST_PAUSE: begin
                    skip_next = skip - 3'd1;
                    if (skip != 3'd1) begin
                        state_next = ST_PAUSE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (expired) begin
            abort      = 1'b1;
            state_next = ST_IDLE;
        end

        tmo_next = (state_next == ST_IDLE || rx_valid) ? 21'd0 : tmo_cnt + 21'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_down    <= '0;
            last_change <= '0;
            key_valid   <= 1'b0;
            seq_abort   <= 1'b0;
        end else begin
            key_valid <= ev;
            seq_abort <= abort;
            if (ev) begin
                key_down[ev_idx] <= !ev_brk;
                last_change      <= ev_idx;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker with a short timeout.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_err = 1'b0;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         seq_abort;

    int checks = 0;
    int failures = 0;
    int kv_cnt = 0;
    int ab_cnt = 0;
    int both_cnt = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .seq_abort   (seq_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (key_valid) kv_cnt++;
        if (seq_abort) ab_cnt++;
        if (key_valid && seq_abort) both_cnt++;
    end

    // Called at a negedge; returns at the next negedge with the result visible
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
            failures++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        checks++;
        if (key_down !== '0) begin
            $display("FAIL reset_key_down got=%h exp=0", key_down);
            failures++;
        end
        checks++;
        if (last_change !== 9'd0) begin
            $display("FAIL reset_last got=%h exp=000", last_change);
            failures++;
        end
        chk_bit("reset_key_valid", key_valid, 1'b0);
        chk_bit("reset_seq_abort", seq_abort, 1'b0);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_make_break;
        int kv0;
        kv0 = kv_cnt;
        send(8'h1C);
        chk_bit("mk_valid", key_valid, 1'b1);
        chk_bit("mk_bit", key_down[9'h01C], 1'b1);
        checks++;
        if (last_change !== 9'h01C) begin
            $display("FAIL mk_last got=%h exp=01c", last_change);
            failures++;
        end
        idle(1);
        chk_bit("mk_pulse_end", key_valid, 1'b0);
        send(PFX_BRK);
        chk_bit("brk_prefix_no_ev", key_valid, 1'b0);
        send(8'h1C);
        chk_bit("brk_valid", key_valid, 1'b1);
        chk_bit("brk_bit", key_down[9'h01C], 1'b0);
        checks++;
        if (last_change !== 9'h01C) begin
            $display("FAIL brk_last got=%h exp=01c", last_change);
            failures++;
        end
        idle(2);
        checks++;
        if (kv_cnt - kv0 != 2) begin
            $display("FAIL mb_pulses got=%0d exp=2", kv_cnt - kv0);
            failures++;
        end
    endtask

    task automatic test_extended;
        send(PFX_EXT);
        send(8'h75);
        chk_bit("ext_mk_bit", key_down[9'h175], 1'b1);
        chk_bit("ext_mk_plain", key_down[9'h075], 1'b0);
        checks++;
        if (last_change !== 9'h175) begin
            $display("FAIL ext_last got=%h exp=175", last_change);
            failures++;
        end
        send(PFX_EXT);
        send(PFX_BRK);
        send(8'h75);
        chk_bit("ext_brk_valid", key_valid, 1'b1);
        chk_bit("ext_brk_bit", key_down[9'h175], 1'b0);
        chk_bit("ext_brk_plain", key_down[9'h075], 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back;
        int kv0;
        kv0 = kv_cnt;
        for (int i = 0; i < 3; i++) begin
            send(8'h29);
            chk_bit($sformatf("rep%0d_valid", i), key_valid, 1'b1);
            chk_bit($sformatf("rep%0d_bit", i), key_down[KEY_SPACE], 1'b1);
        end
        send(PFX_BRK);
        send(8'h29);
        chk_bit("rep_brk_bit", key_down[KEY_SPACE], 1'b0);
        idle(1);
        checks++;
        if (kv_cnt - kv0 != 4) begin
            $display("FAIL rep_pulses got=%0d exp=4", kv_cnt - kv0);
            failures++;
        end
    endtask

    task automatic test_fake_shift;
        int kv0;
        kv0 = kv_cnt;
        send(PFX_EXT);
        send(FAKE_SHIFT_L);
        send(PFX_EXT);
        send(PFX_BRK);
        send(FAKE_SHIFT_R);
        send(8'hAA);
        idle(1);
        checks++;
        if (kv_cnt - kv0 != 0) begin
            $display("FAIL fake_pulses got=%0d exp=0", kv_cnt - kv0);
            failures++;
        end
    endtask

    task automatic test_pause;
        int kv0, ab0;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        kv0 = kv_cnt;
        ab0 = ab_cnt;
        foreach (seq[i]) send(seq[i]);
        idle(1);
        checks++;
        if (kv_cnt - kv0 != 0 || ab_cnt - ab0 != 0) begin
            $display("FAIL pause_strobes got=%0d/%0d exp=0/0", kv_cnt - kv0, ab_cnt - ab0);
            failures++;
        end
        checks++;
        if (key_down !== '0) begin
            $display("FAIL pause_keys got=%h exp=0", key_down);
            failures++;
        end
        send(8'h66);
        chk_bit("pause_after_valid", key_valid, 1'b1);
        chk_bit("pause_after_bit", key_down[KEY_BACK], 1'b1);
        checks++;
        if (last_change !== KEY_BACK) begin
            $display("FAIL pause_after_last got=%h exp=066", last_change);
            failures++;
        end
        idle(1);
    endtask

    task automatic test_timeout;
        int ab0;
        ab0 = ab_cnt;
        send(PFX_BRK);
        idle(TMO - 1);
        chk_bit("tmo_early", seq_abort, 1'b0);
        idle(1);
        chk_bit("tmo_abort", seq_abort, 1'b1);
        chk_bit("tmo_no_ev", key_valid, 1'b0);
        idle(1);
        chk_bit("tmo_pulse_end", seq_abort, 1'b0);
        checks++;
        if (ab_cnt - ab0 != 1) begin
            $display("FAIL tmo_pulses got=%0d exp=1", ab_cnt - ab0);
            failures++;
        end
        send(8'h1C);
        chk_bit("tmo_then_make", key_down[9'h01C], 1'b1);
        // byte landing exactly on the expiry cycle is decoded from IDLE
        send(PFX_BRK);
        idle(TMO - 1);
        send(8'h1B);
        chk_bit("tmo_edge_valid", key_valid, 1'b1);
        chk_bit("tmo_edge_abort", seq_abort, 1'b0);
        chk_bit("tmo_edge_make", key_down[9'h01B], 1'b1);
        idle(2);
        checks++;
        if (ab_cnt - ab0 != 1) begin
            $display("FAIL tmo_edge_pulses got=%0d exp=1", ab_cnt - ab0);
            failures++;
        end
    endtask

    task automatic test_errors;
        send(PFX_EXT);
        rx_err = 1'b1;
        idle(1);
        rx_err = 1'b0;
        chk_bit("err_abort", seq_abort, 1'b1);
        chk_bit("err_no_ev", key_valid, 1'b0);
        send(8'h75);
        chk_bit("err_then_plain", key_down[9'h075], 1'b1);
        chk_bit("err_then_ext", key_down[9'h175], 1'b0);
        rx_err = 1'b1;
        send(8'h33);
        rx_err = 1'b0;
        chk_bit("err_idle_abort", seq_abort, 1'b0);
        chk_bit("err_idle_drop", key_down[9'h033], 1'b0);
        send(PFX_BRK);
        send(PFX_EXT);
        chk_bit("pfx_in_brk_abort", seq_abort, 1'b1);
        chk_bit("pfx_in_brk_no_ev", key_valid, 1'b0);
        send(8'h22);
        chk_bit("pfx_then_make", key_down[9'h022], 1'b1);
        idle(1);
    endtask

    task automatic test_reset_mid;
        send(PFX_BRK);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++;
        if (key_down !== '0 || last_change !== 9'd0 || key_valid !== 1'b0 || seq_abort !== 1'b0) begin
            $display("FAIL rst_mid_outputs got=%h/%h/%b/%b exp=0",
                     key_down, last_change, key_valid, seq_abort);
            failures++;
        end
        send(8'h2D);
        chk_bit("rst_mid_make", key_down[9'h02D], 1'b1);
        checks++;
        if (last_change !== 9'h02D) begin
            $display("FAIL rst_mid_last got=%h exp=02d", last_change);
            failures++;
        end
        idle(2);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_make_break();
        test_extended();
        test_back_to_back();
        test_fake_shift();
        test_pause();
        test_timeout();
        test_errors();
        test_reset_mid();
        checks++;
        if (both_cnt != 0) begin
            $display("FAIL strobe_overlap got=%0d exp=0", both_cnt);
            failures++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
